// File: rtl/uart_echo_ctrl_pkg.sv
// Shared types and constants for the greeting + echo controller.
//   state_e   : controller FSM states
//   AsciiCr/Lf: line-control characters
//   idx_width : index width helper that never returns zero
package uart_echo_ctrl_pkg;

  typedef enum logic [2:0] {
    StGreet,
    StIdle,
    StSend,
    StWaitHi,
    StWaitLo
  } state_e;

  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;

  // Bits needed to index n items; at least 1 so a one-entry table still has an index.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with exact occupancy count.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and data (ignored when full unless popping in the same cycle)
//   pop_i         : read request (ignored when empty); data_o is the current head
//   full_o/empty_o: status flags, count_o: occupancy 0..DEPTH
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full_o   = (count_q == FullCnt);
    empty_o  = (count_q == '0);
    pop_ok   = pop_i && !empty_o;
    // A pop frees a slot this cycle, so a simultaneous push into a full FIFO is accepted.
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_echo_ctrl.sv
// Greeting + echo controller between board logic and a uart core.
// Sends a banner after reset (or on greet_req), buffers received bytes and echoes them back,
// byte by byte (ECHO_MODE 0) or a line at a time (ECHO_MODE 1).
//   CLK, RST_N : clock, asynchronous active-low reset
//   greet_req  : pulse, replay the banner once the current byte / line drain is done
//   rx_valid/rx_data : received byte strobe and data from the uart core
//   tx_busy    : uart core is_transmitting
//   tx_start/tx_data : one-cycle transmit pulse and byte (held until the next pulse)
//   fifo_count : RX FIFO occupancy, overflow: sticky dropped-byte flag
//   greet_done : first banner fully handed off
module uart_echo_ctrl
  import uart_echo_ctrl_pkg::*;
#(
  parameter int unsigned               GREETING_LEN = 10,
  parameter logic [8*GREETING_LEN-1:0] GREETING     = "\nWelcome:\n",
  parameter int unsigned               FIFO_DEPTH   = 8,
  parameter int unsigned               ECHO_MODE    = 0,
  parameter logic [7:0]                EOL_CHAR     = AsciiCr
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        greet_req,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  input  logic                        tx_busy,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        greet_done
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned   IW      = idx_width(GREETING_LEN);
  localparam logic [IW-1:0] LastIdx = IW'(GREETING_LEN - 1);
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          greeting_q, greeting_d;    // current handshake belongs to the banner
  logic          greet_pend_q, greet_pend_d;
  logic          line_rel_q, line_rel_d;
  logic          overflow_q, overflow_d;
  logic          greet_done_q, greet_done_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    byte_q, byte_d;            // popped byte waiting for the uart to go idle

  logic          fifo_pop, fifo_full, fifo_empty, push_ok, want_pop;
  logic [7:0]    fifo_head, greet_byte;
  logic [CW-1:0] fifo_cnt, cnt_next;
  logic [8*GREETING_LEN-1:0] greet_shift;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (rx_valid),
    .data_i  (rx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    // Banner ROM: first character sits in the most significant byte.
    greet_shift = GREETING << {idx_q, 3'b000};
    greet_byte  = greet_shift[8*GREETING_LEN-1 -: 8];

    state_d      = state_q;
    idx_d        = idx_q;
    greeting_d   = greeting_q;
    greet_pend_d = greet_pend_q | greet_req;
    greet_done_d = greet_done_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    byte_d       = byte_q;
    fifo_pop     = 1'b0;

    // Line mode: an already released line drains ahead of a pending banner.
    // Byte mode: a pending banner goes ahead of queued bytes.
    if (ECHO_MODE != 0) begin
      want_pop = line_rel_q && !fifo_empty;
    end else begin
      want_pop = !greet_pend_q && !fifo_empty;
    end

    unique case (state_q)
      StGreet: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = greet_byte;
          state_d    = StWaitHi;
          if (idx_q == LastIdx) begin
            idx_d        = '0;
            greeting_d   = 1'b0;
            greet_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      StIdle: begin
        if (want_pop) begin
          // Only dequeue when the uart is free, so a stuck-busy uart leaves bytes counted.
          if (!tx_busy) begin
            fifo_pop = 1'b1;
            byte_d   = fifo_head;
            state_d  = StSend;
          end
        end else if (greet_pend_q) begin
          greet_pend_d = greet_req;
          greeting_d   = 1'b1;
          state_d      = StGreet;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_q;
          state_d    = StWaitHi;
        end
      end
      StWaitHi: begin
        if (tx_busy) begin
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (!tx_busy) begin
          state_d = greeting_q ? StGreet : StIdle;
        end
      end
      default: state_d = StGreet;
    endcase

    push_ok    = rx_valid && (!fifo_full || fifo_pop);
    cnt_next   = fifo_cnt + CW'(push_ok) - CW'(fifo_pop);
    overflow_d = overflow_q | (rx_valid && !push_ok);

    line_rel_d = line_rel_q;
    if ((push_ok && (rx_data == EOL_CHAR)) || (cnt_next == FullCnt)) begin
      line_rel_d = 1'b1;
    end else if (cnt_next == '0) begin
      line_rel_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StGreet;
      idx_q        <= '0;
      greeting_q   <= 1'b1;
      greet_pend_q <= 1'b0;
      line_rel_q   <= 1'b0;
      overflow_q   <= 1'b0;
      greet_done_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      byte_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      greeting_q   <= greeting_d;
      greet_pend_q <= greet_pend_d;
      line_rel_q   <= line_rel_d;
      overflow_q   <= overflow_d;
      greet_done_q <= greet_done_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      byte_q       <= byte_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign fifo_count = fifo_cnt;
  assign overflow   = overflow_q;
  assign greet_done = greet_done_q;

endmodule
